// File: rtl/od_pkg.sv
// rtl/od_pkg.sv - shared default widths for the odd-parity / divisible-by-3 detector
package od_pkg;
  localparam int W_DEF  = 4;
  localparam int CW_DEF = 8;
endpackage

// File: rtl/od_if.sv
// rtl/od_if.sv - word input and flag/counter output bundle for od
interface od_if #(
  parameter int W  = od_pkg::W_DEF,
  parameter int CW = od_pkg::CW_DEF
) ();
  logic [W-1:0]  a;
  logic          a_valid;
  logic          p;
  logic          d;
  logic          out_valid;
  logic [CW-1:0] p_cnt;
  logic [CW-1:0] d_cnt;

  modport master (
    output a, a_valid,
    input  p, d, out_valid, p_cnt, d_cnt
  );

  modport slave (
    input  a, a_valid,
    output p, d, out_valid, p_cnt, d_cnt
  );
endinterface

// File: rtl/od_mod3.sv
// rtl/od_mod3.sv - combinational mod-3 residue of a W-bit word
module od_mod3 #(
  parameter int W = od_pkg::W_DEF
) (
  input  logic [W-1:0] a,
  output logic [1:0]   res
);
  localparam int NC = (W + 1) / 2;

  logic [2*NC-1:0] padded;
  logic [2:0]      sum;

  // 4 == 1 (mod 3), so the residue is the mod-3 sum of the base-4 digits
  always_comb begin
    padded = '0;
    padded[W-1:0] = a;
    res = 2'd0;
    sum = 3'd0;
    for (int i = 0; i < NC; i++) begin
      sum = {1'b0, res} + {1'b0, padded[2*i +: 2]};
      res = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    end
  end
endmodule

// File: rtl/od.sv
// rtl/od.sv - registered odd-parity and divisible-by-3 flags with saturating event counters
module od
  import od_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input logic clk,
  input logic rst,
  od_if.slave bus
);
  logic [1:0]    res;
  logic          p_next;
  logic          d_next;
  logic          p_q;
  logic          d_q;
  logic          ov_q;
  logic [CW-1:0] p_cnt_q;
  logic [CW-1:0] d_cnt_q;

  od_mod3 #(.W(W)) u_mod3 (
    .a   (bus.a),
    .res (res)
  );

  assign p_next = ^bus.a;
  assign d_next = (res == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q     <= 1'b0;
      d_q     <= 1'b0;
      ov_q    <= 1'b0;
      p_cnt_q <= '0;
      d_cnt_q <= '0;
    end else begin
      ov_q <= bus.a_valid;
      if (bus.a_valid) begin
        p_q <= p_next;
        d_q <= d_next;
        // counters stick at all-ones instead of wrapping
        if (p_next && (p_cnt_q != '1)) p_cnt_q <= p_cnt_q + CW'(1);
        if (d_next && (d_cnt_q != '1)) d_cnt_q <= d_cnt_q + CW'(1);
      end
    end
  end

  assign bus.p         = p_q;
  assign bus.d         = d_q;
  assign bus.out_valid = ov_q;
  assign bus.p_cnt     = p_cnt_q;
  assign bus.d_cnt     = d_cnt_q;
endmodule

// File: tb/tb_od.sv
// tb/tb_od.sv - directed table-driven bench for od (default widths and CW=2 saturation)
module tb_od;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  od_if #(.W(4), .CW(8)) bus8 ();
  od_if #(.W(4), .CW(2)) bus2 ();

  od #(.W(4), .CW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  od #(.W(4), .CW(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  typedef struct {
    logic [3:0] a;
    logic       valid;
    logic       exp_p;
    logic       exp_d;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] a, input logic valid);
    bus8.a       = a;
    bus8.a_valid = valid;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] p_tab;
    logic [15:0] d_tab;
    p_tab = 16'h6996;
    d_tab = 16'h9249;
    for (int i = 0; i < 16; i++) begin
      vecs[i].a      = 4'(i);
      vecs[i].valid  = 1'b1;
      vecs[i].exp_p  = p_tab[i];
      vecs[i].exp_d  = d_tab[i];
      vecs[i].exp_ov = 1'b1;
    end

    rst = 1'b1;
    bus8.a = 4'd0;
    bus8.a_valid = 1'b0;
    bus2.a = 4'd0;
    bus2.a_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_p", 32'(bus8.p), 0);
    check("reset_d", 32'(bus8.d), 0);
    check("reset_ov", 32'(bus8.out_valid), 0);
    check("reset_p_cnt", 32'(bus8.p_cnt), 0);
    check("reset_d_cnt", 32'(bus8.d_cnt), 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].a, vecs[i].valid);
      check($sformatf("sweep_p[%0d]", i), 32'(bus8.p), 32'(vecs[i].exp_p));
      check($sformatf("sweep_d[%0d]", i), 32'(bus8.d), 32'(vecs[i].exp_d));
      check($sformatf("sweep_ov[%0d]", i), 32'(bus8.out_valid), 32'(vecs[i].exp_ov));
    end

    step(4'd0, 1'b0);
    check("sweep_p_cnt", 32'(bus8.p_cnt), 8);
    check("sweep_d_cnt", 32'(bus8.d_cnt), 6);
    check("idle_ov", 32'(bus8.out_valid), 0);
    check("idle_hold_p", 32'(bus8.p), 0);
    check("idle_hold_d", 32'(bus8.d), 1);

    step(4'd5, 1'b1);
    check("a5_p", 32'(bus8.p), 0);
    check("a5_d", 32'(bus8.d), 0);
    check("a5_ov", 32'(bus8.out_valid), 1);
    for (int k = 0; k < 2; k++) begin
      step(4'd3, 1'b0);
      check($sformatf("hold_p[%0d]", k), 32'(bus8.p), 0);
      check($sformatf("hold_d[%0d]", k), 32'(bus8.d), 0);
      check($sformatf("hold_ov[%0d]", k), 32'(bus8.out_valid), 0);
    end
    check("hold_p_cnt", 32'(bus8.p_cnt), 8);

    rst = 1'b1;
    step(4'd15, 1'b1);
    check("midrst_p", 32'(bus8.p), 0);
    check("midrst_d", 32'(bus8.d), 0);
    check("midrst_ov", 32'(bus8.out_valid), 0);
    check("midrst_p_cnt", 32'(bus8.p_cnt), 0);
    check("midrst_d_cnt", 32'(bus8.d_cnt), 0);
    rst = 1'b0;
    step(4'd15, 1'b1);
    check("postrst_p", 32'(bus8.p), 0);
    check("postrst_d", 32'(bus8.d), 1);
    check("postrst_ov", 32'(bus8.out_valid), 1);
    check("postrst_p_cnt", 32'(bus8.p_cnt), 0);
    check("postrst_d_cnt", 32'(bus8.d_cnt), 1);
    bus8.a_valid = 1'b0;

    for (int k = 0; k < 5; k++) begin
      bus2.a = 4'd1;
      bus2.a_valid = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("sat_p_cnt[%0d]", k), 32'(bus2.p_cnt), (k < 2) ? k + 1 : 3);
      check($sformatf("sat_d_cnt[%0d]", k), 32'(bus2.d_cnt), 0);
    end
    check("sat_p", 32'(bus2.p), 1);
    bus2.a_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
